// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_pkg
//  Description : Shared constants and state encodings for the MIPS pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IF_ST_IDLE = 2'd0,
        IF_ST_RUN  = 2'd1,
        IF_ST_HALT = 2'd2
    } if_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_memory
//  Description : Word-addressed instruction RAM, one synchronous write port
//                and one combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);

    // No reset: contents must survive a core reset so a loaded program can be re-run.
    logic [NB_DATA-1:0] r_mem [2**NB_ADDR];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/seg_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : seg_instruction_fetch
//  Description : IF stage: PC, loadable instruction memory, IF/ID register and
//                IDLE/RUN/HALT control. Define IF_STEP_EN for single-step mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_instruction_fetch
    import mips_pkg::*;
#(
    parameter int          LEN         = 32,
    parameter int          NB_ADDR_MEM = 8,
    parameter logic [31:0] HALT_WORD   = DEFAULT_HALT_WORD
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_load_en,
    input  logic [NB_ADDR_MEM-1:0] i_load_addr,
    input  logic [LEN-1:0]         i_load_data,
    input  logic                   i_jump_flag,
    input  logic [LEN-1:0]         i_PC_dir_jump,
    input  logic                   i_branch_flag,
    input  logic [LEN-1:0]         i_PC_branch,
    input  logic                   i_stall_flag,
`ifdef IF_STEP_EN
    input  logic                   i_step,
`endif
    output logic [LEN-1:0]         o_PC,
    output logic [LEN-1:0]         o_instruction,
    output logic [LEN-1:0]         o_pc_current,
    output logic                   o_halt,
    output logic                   o_running
);

    if_state_t      r_state;
    logic [LEN-1:0] r_pc;
    logic [LEN-1:0] r_if_pc;
    logic [LEN-1:0] r_if_instr;

    logic [LEN-1:0] w_fetch_word;
    logic [LEN-1:0] w_pc_next;
    logic           w_mem_we;
    logic           w_advance;

    assign w_mem_we  = i_load_en && (r_state == IF_ST_IDLE);
    assign w_pc_next = r_pc + {{(LEN-1){1'b0}}, 1'b1};

`ifdef IF_STEP_EN
    assign w_advance = i_step;
`else
    assign w_advance = 1'b1;
`endif

    instruction_memory #(
        .NB_DATA (LEN),
        .NB_ADDR (NB_ADDR_MEM)
    ) u_instruction_memory (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (i_load_addr),
        .i_wdata (i_load_data),
        .i_raddr (r_pc[NB_ADDR_MEM-1:0]),
        .o_rdata (w_fetch_word)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= IF_ST_IDLE;
            r_pc       <= '0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            case (r_state)
                IF_ST_IDLE: begin
                    if (i_start) begin
                        r_state <= IF_ST_RUN;
                    end
                end
                IF_ST_RUN: begin
                    // Redirects win over a stall; the flushed slot becomes a NOP.
                    if (i_branch_flag) begin
                        r_pc       <= i_PC_branch;
                        r_if_pc    <= '0;
                        r_if_instr <= NOP_WORD[LEN-1:0];
                    end else if (i_jump_flag) begin
                        r_pc       <= i_PC_dir_jump;
                        r_if_pc    <= '0;
                        r_if_instr <= NOP_WORD[LEN-1:0];
                    end else if (i_stall_flag || !w_advance) begin
                        r_pc <= r_pc;
                    end else if (w_fetch_word == HALT_WORD[LEN-1:0]) begin
                        r_if_pc    <= '0;
                        r_if_instr <= NOP_WORD[LEN-1:0];
                        r_state    <= IF_ST_HALT;
                    end else begin
                        r_pc       <= w_pc_next;
                        r_if_pc    <= w_pc_next;
                        r_if_instr <= w_fetch_word;
                    end
                end
                IF_ST_HALT: begin
                    r_state <= IF_ST_HALT;
                end
                default: begin
                    r_state <= IF_ST_IDLE;
                end
            endcase
        end
    end

    assign o_PC          = r_if_pc;
    assign o_instruction = r_if_instr;
    assign o_pc_current  = r_pc;
    assign o_halt        = (r_state == IF_ST_HALT);
    assign o_running     = (r_state == IF_ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_seg_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_instruction_fetch
//  Description : Self-checking bench for seg_instruction_fetch against a
//                cycle-level behavioural model; honours IF_STEP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_instruction_fetch;

    localparam int          LEN  = 32;
    localparam int          NBA  = 8;
    localparam int          DEPTH = 256;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            load_en = 1'b0;
    logic [NBA-1:0]  load_addr = '0;
    logic [LEN-1:0]  load_data = '0;
    logic            jump = 1'b0;
    logic [LEN-1:0]  jtarget = '0;
    logic            branch = 1'b0;
    logic [LEN-1:0]  btarget = '0;
    logic            stall = 1'b0;
`ifdef IF_STEP_EN
    logic            step = 1'b1;
`endif
    logic [LEN-1:0]  o_PC, o_instruction, o_pc_current;
    logic            o_halt, o_running;

    always #5 clk = ~clk;

    seg_instruction_fetch #(.LEN(LEN), .NB_ADDR_MEM(NBA), .HALT_WORD(HALT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_load_en     (load_en),
        .i_load_addr   (load_addr),
        .i_load_data   (load_data),
        .i_jump_flag   (jump),
        .i_PC_dir_jump (jtarget),
        .i_branch_flag (branch),
        .i_PC_branch   (btarget),
        .i_stall_flag  (stall),
`ifdef IF_STEP_EN
        .i_step        (step),
`endif
        .o_PC          (o_PC),
        .o_instruction (o_instruction),
        .o_pc_current  (o_pc_current),
        .o_halt        (o_halt),
        .o_running     (o_running)
    );

    // Model: mode 0 = idle, 1 = running, 2 = halted.
    logic [31:0] m_mem [DEPTH];
    int          m_mode = 0;
    logic [31:0] m_pc = '0, m_ifpc = '0, m_ifin = '0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] w;
        bit          go;
        go = 1'b1;
`ifdef IF_STEP_EN
        go = step;
`endif
        if (!rst) begin
            m_mode = 0; m_pc = 0; m_ifpc = 0; m_ifin = 0;
        end else if (m_mode == 0) begin
            if (load_en) m_mem[int'(load_addr)] = load_data;
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            w = m_mem[int'(m_pc % DEPTH)];
            if (branch) begin
                m_pc = btarget; m_ifpc = 0; m_ifin = 0;
            end else if (jump) begin
                m_pc = jtarget; m_ifpc = 0; m_ifin = 0;
            end else if (stall || !go) begin
                // frozen
            end else if (w == HALT) begin
                m_ifpc = 0; m_ifin = 0; m_mode = 2;
            end else begin
                m_pc = m_pc + 1; m_ifpc = m_pc; m_ifin = w;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("o_pc_current", o_pc_current, m_pc);
        check("o_PC", o_PC, m_ifpc);
        check("o_instruction", o_instruction, m_ifin);
        check("o_halt", {31'b0, o_halt}, {31'b0, m_mode == 2});
        check("o_running", {31'b0, o_running}, {31'b0, m_mode == 1});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en = 1'b1; load_addr = NBA'(a); load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    initial begin
        logic [31:0] pc0;
        do_reset();
        check("reset o_PC", o_PC, 32'h0);
        check("reset o_instruction", o_instruction, 32'h0);
        check("reset o_pc_current", o_pc_current, 32'h0);
        check("reset o_halt", {31'b0, o_halt}, 32'h0);
        check("reset o_running", {31'b0, o_running}, 32'h0);

        // Fill memory so nothing fetched is ever uninitialised.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       load(i, 32'h2001_0005);
                1:       load(i, 32'h2002_0003);
                2:       load(i, HALT);
                4:       load(i, 32'h0000_0444);
                16:      load(i, 32'h0000_1010);
                default: load(i, $urandom & 32'h7FFF_FFFF);
            endcase
        end

        // Program load and halt detection.
        start = 1'b1; tick(); start = 1'b0;
        check("start running", {31'b0, o_running}, 32'h1);
        tick();
        check("prog instr0", o_instruction, 32'h2001_0005);
        check("prog PC0", o_PC, 32'h1);
        tick();
        check("prog instr1", o_instruction, 32'h2002_0003);
        check("prog PC1", o_PC, 32'h2);
        tick();
        check("halt rise", {31'b0, o_halt}, 32'h1);
        check("halt pc", o_pc_current, 32'h2);
        check("halt running low", {31'b0, o_running}, 32'h0);
        jump = 1'b1; jtarget = 32'h40;
        tick();
        jump = 1'b0;
        check("halt pc held", o_pc_current, 32'h2);
        load(2, 32'h1234_5678);
        check("load ignored in halt", {31'b0, o_halt}, 32'h1);

        // Load and start in the same idle cycle; first fetch sees the new word.
        do_reset();
        load(2, 32'h0000_0222);
        load_en = 1'b1; load_addr = 8'h00; load_data = 32'h0000_0AAA; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        tick();
        check("same-cycle load", o_instruction, 32'h0000_0AAA);
        check("same-cycle PC", o_PC, 32'h1);
        tick(); tick(); tick();
        check("pc at 4", o_pc_current, 32'h4);

        // Stall for two cycles.
        stall = 1'b1;
        tick();
        check("stall1 pc", o_pc_current, 32'h4);
        check("stall1 o_PC", o_PC, 32'h4);
        tick();
        check("stall2 pc", o_pc_current, 32'h4);
        check("stall2 o_PC", o_PC, 32'h4);
        stall = 1'b0;
        tick();
        check("post-stall instr", o_instruction, 32'h0000_0444);
        check("post-stall PC", o_PC, 32'h5);
        tick();

        // Jump at PC=6.
        check("pre-jump pc", o_pc_current, 32'h6);
        jump = 1'b1; jtarget = 32'h10;
        tick();
        jump = 1'b0;
        check("jump pc", o_pc_current, 32'h10);
        check("jump nop", o_instruction, 32'h0);
        check("jump nop PC", o_PC, 32'h0);
        tick();
        check("jump target instr", o_instruction, 32'h0000_1010);
        check("jump target PC", o_PC, 32'h11);

        // Branch beats jump beats stall.
        branch = 1'b1; btarget = 32'h20; jump = 1'b1; jtarget = 32'h30; stall = 1'b1;
        tick();
        branch = 1'b0; jump = 1'b0; stall = 1'b0;
        check("branch pc", o_pc_current, 32'h20);
        check("branch nop", o_instruction, 32'h0);
        check("branch nop PC", o_PC, 32'h0);

        // Reset in the middle of a run; memory survives.
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("pc at 9", o_pc_current, 32'h9);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrun rst pc", o_pc_current, 32'h0);
        check("midrun rst o_PC", o_PC, 32'h0);
        check("midrun rst instr", o_instruction, 32'h0);
        check("midrun rst running", {31'b0, o_running}, 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("rerun instr0", o_instruction, 32'h0000_0AAA);

`ifdef IF_STEP_EN
        pc0 = o_pc_current;
        for (int i = 0; i < 10; i++) begin
            step = (i == 1 || i == 4 || i == 7);
            tick();
        end
        step = 1'b1;
        check("step advance", o_pc_current, pc0 + 32'd3);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 59) != 0);
            start     = ($urandom_range(0, 3) == 0);
            load_en   = ($urandom_range(0, 2) == 0);
            load_addr = NBA'($urandom);
            load_data = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            jump      = ($urandom_range(0, 9) == 0);
            branch    = ($urandom_range(0, 11) == 0);
            stall     = ($urandom_range(0, 5) == 0);
            jtarget   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 511));
            btarget   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 511));
`ifdef IF_STEP_EN
            step      = ($urandom_range(0, 1) == 0);
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
